// File: rtl/rgb_ctrl_pkg.sv
// rtl/rgb_ctrl_pkg.sv - register map, response codes and helpers for the RGB PWM peripheral
package rgb_ctrl_pkg;

  localparam logic [3:0] REG_CTRL  = 4'h0;
  localparam logic [3:0] REG_RED   = 4'h4;
  localparam logic [3:0] REG_GREEN = 4'h8;
  localparam logic [3:0] REG_BLUE  = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_RESP} rd_state_e;

  function automatic logic [1:0] reg_idx(input logic [3:0] off);
    return off[3:2];
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rgb_pwm_core.sv
// rtl/rgb_pwm_core.sv - prescaler, period counter, shadow duties and registered LED outputs
module rgb_pwm_core
  import rgb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  logic [7:0] presc_cnt;
  logic [7:0] presc_q;
  logic [7:0] cnt;
  logic [7:0] shadow_r, shadow_g, shadow_b;
  logic       tick;

  // presc_q only follows presc at a reload, so a mid-period PRESC write waits its turn
  assign tick = en && (presc_cnt == presc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      presc_q   <= '0;
      cnt       <= '0;
      shadow_r  <= '0;
      shadow_g  <= '0;
      shadow_b  <= '0;
      led_r     <= 1'b0;
      led_g     <= 1'b0;
      led_b     <= 1'b0;
    end else begin
      if (!en) begin
        presc_cnt <= '0;
        presc_q   <= presc;
        cnt       <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        presc_q   <= presc;
        cnt       <= cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end

      if (!en || (tick && cnt == 8'hFF)) begin
        shadow_r <= duty_r;
        shadow_g <= duty_g;
        shadow_b <= duty_b;
      end

      led_r <= en && (cnt < shadow_r);
      led_g <= en && (cnt < shadow_g);
      led_b <= en && (cnt < shadow_b);
    end
  end

endmodule

// File: rtl/rgb_pwm_axil_slave.sv
// rtl/rgb_pwm_axil_slave.sv - AXI4-Lite register bank driving a three-channel PWM core
module rgb_pwm_axil_slave
  import rgb_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            LED_R,
  output logic                            LED_G,
  output logic                            LED_B
);

  wr_state_e   wr_state;
  rd_state_e   rd_state;
  logic [31:0] regs [4];
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic [31:0] ctrl;
  logic        unused_ok;

  assign wr_idx      = S_AXI_AWADDR[3:2];
  assign rd_idx      = S_AXI_ARADDR[3:2];
  assign ctrl        = regs[reg_idx(REG_CTRL)];
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;
  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // AW and W are accepted together; the master holds address and data through the ACCEPT cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state      <= WR_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          regs[wr_idx]  <= apply_wstrb(regs[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);
          S_AXI_BVALID  <= 1'b1;
          wr_state      <= WR_RESP;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wr_state     <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // RDATA samples the bank at the same edge a concurrent write lands, so it sees the old value
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state      <= RD_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (S_AXI_ARVALID && !S_AXI_RVALID) begin
            S_AXI_ARREADY <= 1'b1;
            rd_state      <= RD_ACCEPT;
          end
        end
        RD_ACCEPT: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RDATA   <= regs[rd_idx];
          S_AXI_RVALID  <= 1'b1;
          rd_state      <= RD_RESP;
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rd_state     <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  rgb_pwm_core u_core (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .en     (ctrl[CTRL_EN_BIT]),
    .presc  (ctrl[CTRL_PRESC_MSB:CTRL_PRESC_LSB]),
    .duty_r (regs[reg_idx(REG_RED)][7:0]),
    .duty_g (regs[reg_idx(REG_GREEN)][7:0]),
    .duty_b (regs[reg_idx(REG_BLUE)][7:0]),
    .led_r  (LED_R),
    .led_g  (LED_G),
    .led_b  (LED_B)
  );

endmodule

// File: tb/tb_rgb_pwm_axil_slave.sv
// tb/tb_rgb_pwm_axil_slave.sv - directed register and PWM checks for rgb_pwm_axil_slave
module tb_rgb_pwm_axil_slave;
  import rgb_ctrl_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        LED_R, LED_G, LED_B;

  int   n_vec = 0;
  int   n_err = 0;
  int   per_len [2];
  int   per_r [2];
  int   per_g [2];
  int   per_b [2];
  logic started = 1'b0;
  logic [31:0] rd;

  rgb_pwm_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_wr_accept();
    int n = 0;
    logic hs = 1'b0;
    do begin
      @(negedge ACLK);
      hs = S_AXI_AWREADY && S_AXI_WREADY;
      n++;
      @(posedge ACLK); #1;
    end while (!hs && n < 50);
    check("wr_accept", 32'(hs), 32'd1);
  endtask

  task automatic wait_b();
    int n = 0;
    logic got = 1'b0;
    logic [1:0] resp = 2'b11;
    S_AXI_BREADY = 1'b1;
    do begin
      @(negedge ACLK);
      got = S_AXI_BVALID;
      resp = S_AXI_BRESP;
      n++;
      @(posedge ACLK); #1;
    end while (!got && n < 50);
    S_AXI_BREADY = 1'b0;
    check("bvalid", 32'(got), 32'd1);
    check("bresp", 32'(resp), 32'(RESP_OKAY));
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    wait_wr_accept();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n = 0;
    logic hs = 1'b0;
    logic [1:0] resp = 2'b11;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    do begin
      @(negedge ACLK); hs = S_AXI_ARREADY; n++;
      @(posedge ACLK); #1;
    end while (!hs && n < 50);
    S_AXI_ARVALID = 1'b0;
    check("rd_accept", 32'(hs), 32'd1);
    S_AXI_RREADY = 1'b1;
    n = 0; hs = 1'b0; data = '0;
    do begin
      @(negedge ACLK); hs = S_AXI_RVALID; data = S_AXI_RDATA; resp = S_AXI_RRESP; n++;
      @(posedge ACLK); #1;
    end while (!hs && n < 50);
    S_AXI_RREADY = 1'b0;
    check("rvalid", 32'(hs), 32'd1);
    check("rresp", 32'(resp), 32'(RESP_OKAY));
  endtask

  // Syncs to a LED_R rising edge, then counts each channel's high samples per red period
  task automatic meas(input int nper);
    int n = 0;
    logic prev, cur, rise;
    started = 1'b0;
    @(negedge ACLK); prev = LED_R; rise = 1'b0;
    do begin
      @(negedge ACLK); cur = LED_R; rise = !prev && cur; prev = cur; n++;
    end while (!rise && n < 5000);
    check("pwm_rise", 32'(rise), 32'd1);
    started = 1'b1;
    for (int p = 0; p < nper; p++) begin
      per_len[p] = 0; per_r[p] = 0; per_g[p] = 0; per_b[p] = 0;
      do begin
        per_len[p]++;
        per_r[p] += int'(LED_R);
        per_g[p] += int'(LED_G);
        per_b[p] += int'(LED_B);
        @(negedge ACLK); cur = LED_R; rise = !prev && cur; prev = cur;
      end while (!rise && per_len[p] < 5000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #100;
    @(negedge ACLK);
    check("reset_ctl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                            S_AXI_RVALID, LED_R, LED_G, LED_B}), 32'd0);
    check("reset_resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    check("reset_rdata", S_AXI_RDATA, 32'd0);
    #(200 - $time);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    axi_read(REG_CTRL, rd);  check("rst_ctrl", rd, 32'd0);
    axi_read(REG_RED, rd);   check("rst_red", rd, 32'd0);
    axi_read(REG_GREEN, rd); check("rst_green", rd, 32'd0);
    axi_read(REG_BLUE, rd);  check("rst_blue", rd, 32'd0);
    check("rst_leds", 32'({LED_R, LED_G, LED_B}), 32'd0);

    axi_write(REG_CTRL, 32'h1, 4'hF);
    axi_write(REG_RED, 32'h2, 4'hF);
    axi_write(REG_GREEN, 32'h3, 4'hF);
    axi_write(REG_BLUE, 32'h4, 4'hF);
    axi_read(REG_CTRL, rd);  check("seq_ctrl", rd, 32'h1);
    axi_read(REG_RED, rd);   check("seq_red", rd, 32'h2);
    axi_read(REG_GREEN, rd); check("seq_green", rd, 32'h3);
    axi_read(REG_BLUE, rd);  check("seq_blue", rd, 32'h4);

    axi_write(REG_RED, 32'h0000_0002, 4'hF);
    axi_write(REG_RED, 32'hAABB_CCDD, 4'b0010);
    axi_read(REG_RED, rd); check("wstrb_byte1", rd, 32'h0000_CC02);

    fork
      axi_write(REG_RED, 32'h1234_5678, 4'hF);
      axi_read(REG_RED, rd);
    join
    check("rw_same_old", rd, 32'h0000_CC02);
    axi_read(REG_RED, rd); check("rw_same_new", rd, 32'h1234_5678);

    // W presented ahead of AW, then B stalled with a second write queued behind it
    S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    repeat (5) begin
      @(negedge ACLK); check("w_early_wready", 32'(S_AXI_WREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR = REG_GREEN; S_AXI_AWVALID = 1'b1;
    wait_wr_accept();
    S_AXI_AWADDR = REG_BLUE; S_AXI_WDATA = 32'h22;
    repeat (10) begin
      @(negedge ACLK);
      check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      check("aw_blocked", 32'(S_AXI_AWREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    wait_b();
    wait_wr_accept();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    wait_b();
    axi_read(REG_BLUE, rd); check("queued_wr", rd, 32'h22);

    S_AXI_ARADDR = REG_GREEN; S_AXI_ARVALID = 1'b1;
    begin
      int n = 0;
      logic hs = 1'b0;
      do begin
        @(negedge ACLK); hs = S_AXI_ARREADY; n++;
        @(posedge ACLK); #1;
      end while (!hs && n < 50);
      check("rd_accept", 32'(hs), 32'd1);
    end
    S_AXI_ARVALID = 1'b0;
    repeat (6) begin
      @(negedge ACLK);
      check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      check("rdata_hold", S_AXI_RDATA, 32'h11);
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK); check("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);

    axi_write(REG_CTRL, 32'h0, 4'hF);
    repeat (2) @(negedge ACLK);
    check("en0_leds", 32'({LED_R, LED_G, LED_B}), 32'd0);

    axi_write(REG_RED, 32'h40, 4'hF);
    axi_write(REG_GREEN, 32'hFF, 4'hF);
    axi_write(REG_BLUE, 32'h00, 4'hF);
    axi_write(REG_CTRL, 32'h1, 4'hF);
    meas(1);
    check("p0_len", per_len[0], 32'd256);
    check("p0_red", per_r[0], 32'd64);
    check("p0_green", per_g[0], 32'd255);
    check("p0_blue", per_b[0], 32'd0);

    axi_write(REG_CTRL, 32'h301, 4'hF);
    repeat (1100) @(posedge ACLK);
    #1;
    meas(1);
    check("p3_len", per_len[0], 32'd1024);
    check("p3_red", per_r[0], 32'd256);
    check("p3_green", per_g[0], 32'd1020);
    check("p3_blue", per_b[0], 32'd0);

    axi_write(REG_CTRL, 32'h1, 4'hF);
    repeat (1100) @(posedge ACLK);
    #1;
    fork
      meas(2);
      begin
        int n = 0;
        while (!started && n < 6000) begin @(posedge ACLK); n++; end
        repeat (100) @(posedge ACLK);
        #1;
        axi_write(REG_RED, 32'h80, 4'hF);
      end
    join
    check("shadow_cur_len", per_len[0], 32'd256);
    check("shadow_cur_red", per_r[0], 32'd64);
    check("shadow_next_len", per_len[1], 32'd256);
    check("shadow_next_red", per_r[1], 32'd128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
